// File: rtl/keypad_matrix_emulator_pkg.sv
// ============================================================================
// keypad_pkg
// Shared types and helpers for the 4x4 matrix-keypad emulator.
//   key_pos_t   : column/row position of a key on the matrix
//   emu_state_t : emulator sequencing states
//   FIL_IDLE    : row lines with no key pressed (active-low, all released)
//   COL_NONE    : column drive with no column selected
//   key_to_pos  : hex key code -> matrix position
// ============================================================================
package keypad_pkg;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] r;
    } key_pos_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } emu_state_t;

    localparam logic [3:0] FIL_IDLE = 4'b1111;
    localparam logic [3:0] COL_NONE = 4'b1111;

    // Physical layout: row 3 is the "1 2 3 A" row, row 0 is "E F D 0".
    function automatic key_pos_t key_to_pos(input logic [3:0] code);
        key_pos_t pos;
        case (code)
            4'h1:    pos = '{c: 2'd0, r: 2'd3};
            4'h2:    pos = '{c: 2'd1, r: 2'd3};
            4'h3:    pos = '{c: 2'd2, r: 2'd3};
            4'hA:    pos = '{c: 2'd3, r: 2'd3};
            4'h4:    pos = '{c: 2'd0, r: 2'd2};
            4'h5:    pos = '{c: 2'd1, r: 2'd2};
            4'h6:    pos = '{c: 2'd2, r: 2'd2};
            4'hB:    pos = '{c: 2'd3, r: 2'd2};
            4'h7:    pos = '{c: 2'd0, r: 2'd1};
            4'h8:    pos = '{c: 2'd1, r: 2'd1};
            4'h9:    pos = '{c: 2'd2, r: 2'd1};
            4'hC:    pos = '{c: 2'd3, r: 2'd1};
            4'hE:    pos = '{c: 2'd0, r: 2'd0};
            4'hF:    pos = '{c: 2'd1, r: 2'd0};
            4'hD:    pos = '{c: 2'd2, r: 2'd0};
            default: pos = '{c: 2'd3, r: 2'd0};   // key 0
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_bounce.sv
// ============================================================================
// keypad_emu_bounce
// Contact-bounce gate for the start of a key press. The gate opens and closes
// every BOUNCE_PERIOD row updates, starting closed, for the first
// BOUNCE_CYCLES updates of a press; afterwards it stays closed.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_start   : the cycle the press begins (row update index 0)
//   i_run     : press in progress (row updates index 1, 2, ...)
//   o_open    : 1 = contact forced open for the current row update
// ============================================================================
module keypad_emu_bounce #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_open
);

    localparam int WIN_W = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int PH_W  = $clog2(BOUNCE_PERIOD + 1);
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(BOUNCE_CYCLES);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BOUNCE_PERIOD - 1);

    // Registers describe the update index that the next edge will produce.
    logic [WIN_W-1:0] r_win;
    logic [PH_W-1:0]  r_phase;
    logic             r_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win   <= '0;
            r_phase <= '0;
            r_open  <= 1'b0;
        end else if (i_start) begin
            // Index 0 is always closed; preload the state of index 1.
            r_win <= WIN_W'(1);
            if (BOUNCE_PERIOD == 1) begin
                r_phase <= '0;
                r_open  <= 1'b1;
            end else begin
                r_phase <= PH_W'(1);
                r_open  <= 1'b0;
            end
        end else if (i_run) begin
            if (r_win < WIN_END) begin
                r_win <= r_win + 1'b1;
            end
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
                r_open  <= ~r_open;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign o_open = i_run && (r_win < WIN_END) && r_open;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// ============================================================================
// keypad_matrix_emulator
// Plays the keypad side of a 4x4 matrix scanner. A hex key accepted over
// key_valid/key_ready is "pressed" once the scanner selects its column: the
// matching row follows that column for PRESS_CYCLES cycles, then all rows are
// released for GAP_CYCLES before the next key is taken.
// Optional build macro: KEYPAD_EMU_BOUNCE_EN adds contact bounce at the start
// of each press (keypad_emu_bounce).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   col[3:0]    : scanner column drive, active-low
//   fil[3:0]    : row lines back to the scanner, active-low, registered
//   key_valid   : key request valid
//   key_code    : hex key to press
//   key_ready   : high only while idle
//   busy        : high while not idle
//   done        : one-cycle pulse when the release gap completes
//   timeout_err : one-cycle pulse when the column never showed up
// ============================================================================
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int PRESS_CYCLES  = 3000,
    parameter int GAP_CYCLES    = 3000,
    parameter int ARM_TIMEOUT   = 65535,
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] fil,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int MAX_PG  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_PG > ARM_TIMEOUT) ? MAX_PG : ARM_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_TIMEOUT - 1);

    generate
        if (PRESS_CYCLES < 1 || GAP_CYCLES < 1 || ARM_TIMEOUT < 1 ||
            BOUNCE_CYCLES < 0 || BOUNCE_PERIOD < 1) begin : g_bad_params
            $error("keypad_matrix_emulator: cycle parameters out of range");
        end
    endgenerate

    emu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    key_pos_t         r_tgt;
    logic [3:0]       r_fil;
    logic             r_key_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_terr;

    logic [3:0] w_col_mask;
    logic       w_col_hit;
    logic       w_open;
    logic       w_contact;
    logic [3:0] w_press_fil;
    logic       w_bounce_start;
    logic       w_bounce_run;

    // Target column is selected when it is low once every other column is
    // masked to "not selected".
    assign w_col_mask = 4'b0001 << r_tgt.c;
    assign w_col_hit  = ((col | ~w_col_mask) != COL_NONE);

    assign w_bounce_start = (r_state == ARM) && w_col_hit;
    assign w_bounce_run   = (r_state == PRESS);

`ifdef KEYPAD_EMU_BOUNCE_EN
    keypad_emu_bounce #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BOUNCE_PERIOD (BOUNCE_PERIOD)
    ) u_bounce (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_bounce_start),
        .i_run   (w_bounce_run),
        .o_open  (w_open)
    );
`else
    assign w_open = 1'b0;
`endif

    // The pressed row follows only the target column, whatever else is low.
    assign w_contact = col[r_tgt.c] | w_open;

    always_comb begin
        w_press_fil          = FIL_IDLE;
        w_press_fil[r_tgt.r] = w_contact;
    end

    // Outputs are written for the state being entered, so fil is low for
    // exactly PRESS_CYCLES cycles and released throughout the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_fil       <= FIL_IDLE;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_terr      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_terr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fil       <= FIL_IDLE;
                    r_key_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (key_valid && r_key_ready) begin
                        r_tgt       <= key_to_pos(key_code);
                        r_cnt       <= '0;
                        r_state     <= ARM;
                        r_key_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ARM: begin
                    if (w_col_hit) begin
                        r_state <= PRESS;
                        r_cnt   <= '0;
                        r_fil   <= w_press_fil;
                    end else if (r_cnt == ARM_LAST) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_terr      <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fil       <= FIL_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_fil <= FIL_IDLE;
                    end
                end
                PRESS: begin
                    if (r_cnt == PRESS_LAST) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        r_fil   <= FIL_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_fil <= w_press_fil;
                    end
                end
                default: begin  // GAP
                    r_fil <= FIL_IDLE;
                    if (r_cnt == GAP_LAST) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_done      <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign fil         = r_fil;
    assign key_ready   = r_key_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_terr;

endmodule
